mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory stage of the 16-bit pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register. It issues loads and stores to a variable-latency data memory over a req/gnt/rvalid handshake and freezes upstream stages while an access is in flight. It presents MEM/WB with a bubble (regWrite cleared) on every stalled cycle and with the completed result on the release cycle.

## Interface
Parameters:
- TIMEOUT, 64: max cycles spent in REQ+RESP before the access is aborted with an error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- regWrite_in, resultSrc_in, memWrite_in  in  1 each  control from EX/MEM; resultSrc_in=1 means load.
- pc_plus2_in  in  16  PC+2 from EX/MEM.
- rd_in  in  4  destination register.
- aluRes_in  in  16  ALU result, used as word address for loads/stores.
- writeData_in  in  16  store data.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store.
- mem_addr, mem_wdata  out  16 each  address and store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid, mem_rdata  in  1 / 16  load response; rvalid never in the same cycle as its gnt.
- stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
- regWrite_out, resultSrc_out  out  1 each  to MEM/WB.
- pc_plus2_out, rd_out, aluRes_out, readData_out  out  16/4/16/16  to MEM/WB.
- mem_err  out  1  sticky timeout flag.

## Operation
- States: IDLE, REQ, RESP, DONE.
- access = resultSrc_in | memWrite_in. A load has priority if both are set. The store is then not performed.
- IDLE, no access:
  - Pure pass-through: all *_out = *_in, readData_out = 0, stall=0.
- IDLE, access:
  - mem_req=1, mem_we=memWrite_in & ~resultSrc_in, mem_addr=aluRes_in, mem_wdata=writeData_in, stall=1.
  - gnt & store → DONE. gnt & load → RESP. No gnt → REQ.
- REQ:
  - Same request outputs held, stall=1.
  - gnt & store → DONE. gnt & load → RESP.
- RESP:
  - mem_req=0, stall=1.
  - rvalid → capture mem_rdata into rdata_q, → DONE.
- DONE:
  - stall=0, all *_out = *_in, readData_out = rdata_q (0 for stores), → IDLE.
  - Upstream advances on this edge, so IDLE sees the next instruction and never reissues.
- While stall=1:
  - regWrite_out=0 and resultSrc_out=0 (bubble into MEM/WB).
  - Other outputs pass through and are don't-care.
- Timeout:
  - A counter clears on entry to REQ/RESP from IDLE and increments each REQ/RESP cycle.
  - On reaching TIMEOUT: mem_err←1 (sticky until reset), rdata_q←16'hDEAD, → DONE.
  - A late gnt/rvalid after an abort is ignored.
- mem_req is never dropped in REQ without gnt or timeout.

## Timing
- Reset (reset=0, asynchronous):
  - State→IDLE, rdata_q=0, counter=0, mem_err=0.
  - Outputs then follow IDLE rules: mem_req=0 only if no access is present at the inputs.
- Reset mid-access abandons the transaction. The memory is responsible for dropping its own state on the same reset.
- Latency, non-memory instruction: 0 cycles added (combinational).
- Latency, store: 1 stall cycle minimum (IDLE with gnt) plus 1 DONE cycle.
- Latency, load: minimum IDLE(gnt) → RESP(rvalid) → DONE, i.e. 2 stall cycles then release.
- Each cycle without gnt or rvalid adds one stall cycle.
- Worst case: TIMEOUT+1 stall cycles, then DONE.
- Counter width is $clog2(TIMEOUT+1) and it saturates.

## Structure
- Shared package pipe_pkg:
  - typedef mem_state_t (IDLE/REQ/RESP/DONE).
  - constants WORD_W=16, REG_AW=4, MEM_ERR_DATA=16'hDEAD.
- No sub-module required. An optional mem_timeout_ctr (load/clear/increment/expired) is a natural split.

## Test plan
- ALU op, resultSrc_in=0, memWrite_in=0, aluRes_in=16'h1234:
  - Same cycle: aluRes_out=16'h1234, regWrite_out=regWrite_in, stall=0, mem_req=0.
- Store addr 16'h0040, data 16'hBEEF, gnt in first cycle:
  - mem_we=1 with addr/data on bus.
  - stall=1 for 1 cycle, then DONE with stall=0, readData_out=0.
- Load addr 16'h0010, gnt after 2 cycles, rvalid 3 cycles later with 16'hA5A5:
  - stall=1 for 5 cycles, regWrite_out=0 throughout.
  - DONE: readData_out=16'hA5A5, regWrite_out=1, rd_out=rd_in.
- Back-to-back loads, memory with gnt and rvalid at minimum latency:
  - Each load gives exactly 2 stall cycles plus 1 DONE.
  - Only one request per instruction.
- Load with no gnt, TIMEOUT=8:
  - After 8 REQ cycles, mem_err=1 and DONE with readData_out=16'hDEAD.
  - mem_err stays 1 across later accesses until reset.
- reset asserted in RESP:
  - stall and mem_req fall asynchronously.
  - After release, the state is IDLE and the next load is issued cleanly.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Types and constants shared by the 16-bit pipeline's memory
//               stage: datapath widths, the memory-access FSM state type and
//               the data returned when an access is aborted.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int          WORD_W       = 16;
    localparam int          REG_AW       = 4;
    localparam logic [15:0] MEM_ERR_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_ctr
// Description : Saturating cycle counter that bounds the time one memory
//               access may spend waiting for gnt/rvalid.
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   i_clr      in   clear the count (held while the stage is idle)
//   i_inc      in   count one waiting cycle
//   o_expired  out  the current waiting cycle is the last one allowed
// Revision    : 1.0  initial release
// ============================================================================
module mem_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts waiting cycles already completed, so the TIMEOUT-th
    // waiting cycle is the one that sees TIMEOUT-1.
    assign o_expired = (cnt_q >= CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Memory stage of the 16-bit pipeline. Issues loads/stores to
//               a variable-latency memory over req/gnt/rvalid, stalls the
//               upstream stages while an access is in flight and presents a
//               bubble to MEM/WB on every stalled cycle.
//   clk, reset                     clock / asynchronous active-low reset
//   *_in                           EX/MEM pipeline register contents
//   mem_req/we/addr/wdata          request side of the memory bus
//   mem_gnt/rvalid/rdata           grant and load response
//   stall                          freezes PC, IF/ID, ID/EX, EX/MEM
//   *_out, readData_out            to MEM/WB
//   mem_err                        sticky timeout flag
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite_in,
    input  logic              resultSrc_in,
    input  logic              memWrite_in,
    input  logic [WORD_W-1:0] pc_plus2_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [WORD_W-1:0] aluRes_in,
    input  logic [WORD_W-1:0] writeData_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              stall,
    output logic              regWrite_out,
    output logic              resultSrc_out,
    output logic [WORD_W-1:0] pc_plus2_out,
    output logic [REG_AW-1:0] rd_out,
    output logic [WORD_W-1:0] aluRes_out,
    output logic [WORD_W-1:0] readData_out,
    output logic              mem_err
);

    mem_state_t        state_q, state_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              mem_err_q, mem_err_d;

    logic w_is_access;
    logic w_is_store;
    logic w_expired;
    logic w_waiting;

    // A load wins when both resultSrc and memWrite are set.
    assign w_is_access = resultSrc_in | memWrite_in;
    assign w_is_store  = memWrite_in & ~resultSrc_in;
    assign w_waiting   = (state_q == REQ) || (state_q == RESP);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (state_q == IDLE),
        .i_inc     (w_waiting),
        .o_expired (w_expired)
    );

    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        mem_err_d    = mem_err_q;
        mem_req      = 1'b0;
        stall        = 1'b0;
        readData_out = '0;

        case (state_q)
            IDLE: begin
                if (w_is_access) begin
                    mem_req = 1'b1;
                    stall   = 1'b1;
                    if (mem_gnt) begin
                        if (w_is_store) begin
                            state_d = DONE;
                            rdata_d = '0;
                        end else begin
                            state_d = RESP;
                        end
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Request stays up until granted or aborted.
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_gnt) begin
                    if (w_is_store) begin
                        state_d = DONE;
                        rdata_d = '0;
                    end else begin
                        state_d = RESP;
                    end
                end else if (w_expired) begin
                    state_d   = DONE;
                    rdata_d   = MEM_ERR_DATA;
                    mem_err_d = 1'b1;
                end
            end
            RESP: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    state_d = DONE;
                    rdata_d = mem_rdata;
                end else if (w_expired) begin
                    state_d   = DONE;
                    rdata_d   = MEM_ERR_DATA;
                    mem_err_d = 1'b1;
                end
            end
            DONE: begin
                // Upstream advances on this edge, so IDLE next sees a new
                // instruction and does not reissue this one.
                readData_out = rdata_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rdata_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_we    = mem_req & w_is_store;
    assign mem_addr  = aluRes_in;
    assign mem_wdata = writeData_in;

    // Bubble into MEM/WB whenever the stage is stalled.
    assign regWrite_out  = regWrite_in  & ~stall;
    assign resultSrc_out = resultSrc_in & ~stall;
    assign pc_plus2_out  = pc_plus2_in;
    assign rd_out        = rd_in;
    assign aluRes_out    = aluRes_in;
    assign mem_err       = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for mem_access_stage with
//               TIMEOUT=8. Inputs are applied 1 time unit after each rising
//               edge and outputs are sampled 1 time unit later.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        regWrite_in, resultSrc_in, memWrite_in;
    logic [15:0] pc_plus2_in;
    logic [3:0]  rd_in;
    logic [15:0] aluRes_in, writeData_in;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [15:0] mem_rdata;
    logic        stall, regWrite_out, resultSrc_out;
    logic [15:0] pc_plus2_out;
    logic [3:0]  rd_out;
    logic [15:0] aluRes_out, readData_out;
    logic        mem_err;

    int n_vec = 0;
    int n_err = 0;

    mem_access_stage #(.TIMEOUT(8)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .regWrite_in   (regWrite_in),
        .resultSrc_in  (resultSrc_in),
        .memWrite_in   (memWrite_in),
        .pc_plus2_in   (pc_plus2_in),
        .rd_in         (rd_in),
        .aluRes_in     (aluRes_in),
        .writeData_in  (writeData_in),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .stall         (stall),
        .regWrite_out  (regWrite_out),
        .resultSrc_out (resultSrc_out),
        .pc_plus2_out  (pc_plus2_out),
        .rd_out        (rd_out),
        .aluRes_out    (aluRes_out),
        .readData_out  (readData_out),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_instr(input logic rw, input logic rs, input logic mw,
                             input logic [3:0] rd, input logic [15:0] alu,
                             input logic [15:0] wd, input logic [15:0] pc);
        regWrite_in  = rw;
        resultSrc_in = rs;
        memWrite_in  = mw;
        rd_in        = rd;
        aluRes_in    = alu;
        writeData_in = wd;
        pc_plus2_in  = pc;
    endtask

    task automatic set_mem(input logic gnt, input logic rv, input logic [15:0] rdata);
        mem_gnt    = gnt;
        mem_rvalid = rv;
        mem_rdata  = rdata;
    endtask

    // Advance to the start of the next cycle's drive window.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // One minimum-latency load: gnt in IDLE, rvalid in RESP, then DONE.
    task automatic fast_load(input logic [3:0] rd, input logic [15:0] addr, input logic [15:0] data);
        int reqs;
        reqs = 0;
        next_cyc();
        set_instr(1'b1, 1'b1, 1'b0, rd, addr, 16'h0000, 16'h0200);
        set_mem(1'b1, 1'b0, 16'h0000);
        #1;
        chk("ld_idle_stall", {15'd0, stall}, 16'd1);
        chk("ld_idle_addr", mem_addr, addr);
        reqs += int'(mem_req);
        next_cyc();
        set_mem(1'b0, 1'b1, data);
        #1;
        chk("ld_resp_stall", {15'd0, stall}, 16'd1);
        reqs += int'(mem_req);
        next_cyc();
        set_mem(1'b0, 1'b0, 16'h0000);
        #1;
        chk("ld_done_stall", {15'd0, stall}, 16'd0);
        chk("ld_done_data", readData_out, data);
        chk("ld_done_rw", {15'd0, regWrite_out}, 16'd1);
        reqs += int'(mem_req);
        chk("ld_req_count", 16'(reqs), 16'd1);
    endtask

    initial begin
        int stalls;
        int reqs;
        int bubbles;

        // ---------------- reset ----------------
        reset = 1'b0;
        set_instr(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000);
        set_mem(1'b0, 1'b0, 16'h0000);
        #12;
        chk("rst_stall", {15'd0, stall}, 16'd0);
        chk("rst_req", {15'd0, mem_req}, 16'd0);
        chk("rst_err", {15'd0, mem_err}, 16'd0);
        chk("rst_rdata", readData_out, 16'h0000);
        #5;
        reset = 1'b1;

        // ---------------- ALU pass-through ----------------
        next_cyc();
        set_instr(1'b1, 1'b0, 1'b0, 4'd3, 16'h1234, 16'h5555, 16'h0102);
        #1;
        chk("alu_res", aluRes_out, 16'h1234);
        chk("alu_rw", {15'd0, regWrite_out}, 16'd1);
        chk("alu_stall", {15'd0, stall}, 16'd0);
        chk("alu_req", {15'd0, mem_req}, 16'd0);
        chk("alu_rd", {12'd0, rd_out}, 16'd3);
        chk("alu_pc", pc_plus2_out, 16'h0102);

        // ---------------- store, gnt in first cycle ----------------
        next_cyc();
        set_instr(1'b0, 1'b0, 1'b1, 4'd0, 16'h0040, 16'hBEEF, 16'h0104);
        set_mem(1'b1, 1'b0, 16'h0000);
        #1;
        chk("st_req", {15'd0, mem_req}, 16'd1);
        chk("st_we", {15'd0, mem_we}, 16'd1);
        chk("st_addr", mem_addr, 16'h0040);
        chk("st_wdata", mem_wdata, 16'hBEEF);
        chk("st_stall", {15'd0, stall}, 16'd1);
        next_cyc();
        set_mem(1'b0, 1'b0, 16'h0000);
        #1;
        chk("st_done_stall", {15'd0, stall}, 16'd0);
        chk("st_done_rdata", readData_out, 16'h0000);
        chk("st_done_req", {15'd0, mem_req}, 16'd0);

        // ---------------- load, gnt at cycle 1, rvalid at cycle 4 ----------------
        stalls  = 0;
        bubbles = 0;
        for (int c = 0; c < 5; c++) begin
            next_cyc();
            if (c == 0) set_instr(1'b1, 1'b1, 1'b0, 4'd5, 16'h0010, 16'h0000, 16'h0106);
            set_mem(c == 1, c == 4, (c == 4) ? 16'hA5A5 : 16'h0000);
            #1;
            stalls  += int'(stall);
            bubbles += int'(regWrite_out | resultSrc_out);
            chk("ld_req_phase", {15'd0, mem_req}, (c < 2) ? 16'd1 : 16'd0);
        end
        chk("ld_stall_cycles", 16'(stalls), 16'd5);
        chk("ld_bubble", 16'(bubbles), 16'd0);
        next_cyc();
        set_mem(1'b0, 1'b0, 16'h0000);
        #1;
        chk("ld_rel_stall", {15'd0, stall}, 16'd0);
        chk("ld_rel_data", readData_out, 16'hA5A5);
        chk("ld_rel_rw", {15'd0, regWrite_out}, 16'd1);
        chk("ld_rel_rs", {15'd0, resultSrc_out}, 16'd1);
        chk("ld_rel_rd", {12'd0, rd_out}, 16'd5);

        // ---------------- back-to-back minimum-latency loads ----------------
        fast_load(4'd6, 16'h0020, 16'h1111);
        fast_load(4'd7, 16'h0022, 16'h2222);

        // ---------------- load timeout, no gnt ----------------
        stalls = 0;
        reqs   = 0;
        for (int c = 0; c < 9; c++) begin
            next_cyc();
            if (c == 0) set_instr(1'b1, 1'b1, 1'b0, 4'd8, 16'h0030, 16'h0000, 16'h0108);
            set_mem(1'b0, 1'b0, 16'h0000);
            #1;
            stalls += int'(stall);
            reqs   += int'(mem_req);
        end
        chk("to_stalls", 16'(stalls), 16'd9);
        chk("to_req_held", 16'(reqs), 16'd9);
        chk("to_err_before", {15'd0, mem_err}, 16'd0);
        next_cyc();
        #1;
        chk("to_done_stall", {15'd0, stall}, 16'd0);
        chk("to_err", {15'd0, mem_err}, 16'd1);
        chk("to_dead", readData_out, 16'hDEAD);
        // Sticky across a later access
        next_cyc();
        set_instr(1'b0, 1'b0, 1'b1, 4'd0, 16'h0050, 16'h7777, 16'h010A);
        set_mem(1'b1, 1'b0, 16'h0000);
        #1;
        chk("to_st_req", {15'd0, mem_req}, 16'd1);
        next_cyc();
        set_mem(1'b0, 1'b0, 16'h0000);
        #1;
        chk("to_st_done_rdata", readData_out, 16'h0000);
        chk("err_sticky", {15'd0, mem_err}, 16'd1);

        // ---------------- reset asserted in RESP ----------------
        next_cyc();
        set_instr(1'b1, 1'b1, 1'b0, 4'd9, 16'h0060, 16'h0000, 16'h010C);
        set_mem(1'b1, 1'b0, 16'h0000);
        next_cyc();
        set_mem(1'b0, 1'b0, 16'h0000);
        #1;
        chk("rr_resp_stall", {15'd0, stall}, 16'd1);
        chk("rr_resp_req", {15'd0, mem_req}, 16'd0);
        #1;
        reset = 1'b0;
        set_instr(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000);
        #1;
        chk("rr_async_stall", {15'd0, stall}, 16'd0);
        chk("rr_async_req", {15'd0, mem_req}, 16'd0);
        chk("rr_err_clr", {15'd0, mem_err}, 16'd0);
        next_cyc();
        #3;
        reset = 1'b1;
        fast_load(4'd10, 16'h0070, 16'h3C3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
